mobius_seq_ctrl: RTL
====================

Name: mobius_seq_ctrl

Overview:
- Sequencing controller for the 2-point Mobius round datapath: butterfly `hi ^= lo` followed by perfect-shuffle permute.
- Accepts one N-bit truth-table vector per valid/ready handshake and iterates the round LOG2_N times on an internal state register.
- Presents the transformed vector (ANF coefficients) on a valid/ready output port.
- Replaces free-running init/round-count logic with explicit start, busy and done sequencing, so consecutive vectors can be streamed.

Parameters:
- N, 64, vector width in bits; must be a power of two, N >= 2.
- LOG2_N, 6, number of rounds; must equal log2(N). Elaboration-time error if mismatched or < 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data holds a vector to transform
- in_ready  output  1  controller can accept a vector this cycle
- in_data  input  [0:N-1]  input truth table, bit 0 = MSB index convention of the datapath
- out_valid  output  1  out_data holds a completed transform
- out_ready  input  1  downstream accepts out_data this cycle
- out_data  output  [0:N-1]  transformed vector (direct view of state register)
- busy  output  1  high while in RUN
- round_idx  output  clog2(LOG2_N+1)  rounds completed on current vector (0..LOG2_N)

Behaviour:
- Reset (async assert, sync-safe deassert, no clock needed to take effect):
  - state = IDLE, data_reg = 0, round_idx = 0.
  - in_ready = 1, out_valid = 0, busy = 0, out_data = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: data_reg <= in_data, round_idx <= 0, go to RUN.
- RUN:
  - in_ready = 0, busy = 1.
  - Each cycle: data_reg <= round(data_reg), round_idx <= round_idx + 1.
  - When round_idx == LOG2_N-1 at the clock edge, the final round is applied and the state goes to DONE (round_idx becomes LOG2_N).
- DONE:
  - out_valid = 1, out_data = data_reg, held stable while out_ready = 0 (no bubbles, no overwrite).
  - On out_ready with in_valid = 0: go to IDLE, round_idx <= 0.
  - On out_ready with in_valid = 1 in the same cycle (back-to-back): in_ready = out_ready in DONE. Load in_data, round_idx <= 0, go to RUN directly.
- in_ready is combinational:
  - 1 in IDLE;
  - equal to out_ready in DONE;
  - 0 in RUN.
- Latency:
  - Vector accepted at edge t gives out_valid high from edge t+LOG2_N.
  - Throughput is one vector per LOG2_N+1 cycles when out_ready is held high.
- Round datapath is purely combinational, applied once per RUN cycle:
  - For i < N/2: m[i] = d[i], m[i+N/2] = d[i+N/2] ^ d[i].
  - Then r[2i] = m[i], r[2i+1] = m[i+N/2].
- in_valid while in RUN is ignored; the upstream must hold the vector since in_ready = 0.
- in_data is sampled only on the accepting edge.
- Reset mid-RUN or mid-DONE discards the vector; out_valid drops immediately.
- No X propagation: data_reg is only written in IDLE, RUN and DONE-accept.

Decomposition:
- Shared package mobius_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - function clog2;
  - parameter-check macro or function used by all Mobius blocks.
- One sub-module, mobius_round (parameter N): the combinational butterfly + shuffle.
- The controller instantiates exactly one mobius_round and contains the FSM, round counter and data register.

Test Plan:
- N=4, LOG2_N=2; reset, then in_data=4'b1000 with in_valid for 1 cycle, out_ready=1 -> in_ready low 2 cycles; out_valid high at accept+2 for one cycle; out_data=4'b1111.
- N=4; in_data=4'b0100, out_ready=0 for 5 cycles then 1 -> out_data=4'b0101 held stable all 5 stall cycles; in_ready=0 during stall; return to IDLE after handshake.
- N=4; stream 4'b0001 then 4'b1000 with in_valid and out_ready continuously high -> outputs 4'b0001 then 4'b1111; second vector accepted in the DONE/out_ready cycle; out_valid pulses spaced 3 cycles apart.
- N=64 default; in_data = 64'h8000_0000_0000_0000 -> out_valid at accept+6, out_data = all ones; round_idx steps 0..6; busy high for exactly 6 cycles.
- Assert rst_n low on the cycle round_idx=1 during RUN -> out_valid=0, in_ready=1, round_idx=0 without a clock edge. Next vector 4'b0100 (N=4) yields 4'b0101 normally.
- Applying the transform twice (feed out_data back as in_data), random vectors, N=8 -> result equals original vector (involution check), 200 iterations.

Source files
------------

// File: rtl/mobius_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mobius_pkg
//  Brief    : Shared types and elaboration helpers for the Mobius blocks:
//             controller state encoding, ceil(log2) and parameter checking.
//  Revision : 1.0  - initial release
// ============================================================================
package mobius_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // True when N is a power of two >= 2 and LOG2_N is exactly log2(N).
    function automatic bit params_ok(input int n, input int log2_n);
        return (n >= 2) && (log2_n >= 1) && (log2_n < 31) && ((1 << log2_n) == n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mobius_round.sv
`default_nettype none
// ============================================================================
//  Module   : mobius_round
//  Brief    : One combinational Mobius round: butterfly (upper half ^= lower
//             half) followed by a perfect-shuffle interleave of the halves.
//             Bit 0 is the MSB-index position of the truth table.
//  Revision : 1.0  - initial release
// ============================================================================
module mobius_round
    import mobius_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [0:N-1] d,
    output logic [0:N-1] r
);

    localparam int C_HALF = N / 2;

    if (!params_ok(N, clog2(N))) begin : g_param_err
        $error("mobius_round: N must be a power of two >= 2");
    end

    // Butterfly result for half i lands interleaved: even slot keeps the
    // lower-half bit, odd slot takes the xored upper-half bit.
    for (genvar i = 0; i < C_HALF; i++) begin : g_bfly
        assign r[2*i]     = d[i];
        assign r[2*i + 1] = d[i + C_HALF] ^ d[i];
    end

endmodule
`default_nettype wire

// File: rtl/mobius_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mobius_seq_ctrl
//  Brief    : Start/busy/done sequencer around the Mobius round datapath.
//             Loads a vector on an input handshake, applies LOG2_N rounds on
//             an internal register, then holds the result on a valid/ready
//             output. A new vector may be accepted in the same cycle the
//             result is consumed.
//  Revision : 1.0  - initial release
// ============================================================================
module mobius_seq_ctrl
    import mobius_pkg::*;
#(
    parameter int  N      = 64,
    parameter int  LOG2_N = 6,
    localparam int RIW    = clog2(LOG2_N + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [0:N-1]   in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [0:N-1]   out_data,
    output logic           busy,
    output logic [RIW-1:0] round_idx
);

    if (!params_ok(N, LOG2_N)) begin : g_param_err
        $error("mobius_seq_ctrl: N must equal 2**LOG2_N with LOG2_N >= 1");
    end

    localparam logic [RIW-1:0] c_last_round = RIW'(LOG2_N - 1);

    state_t         r_state;
    state_t         w_state_next;
    logic [0:N-1]   r_data;
    logic [0:N-1]   w_round_out;
    logic [RIW-1:0] r_round_idx;
    logic           w_load;
    logic           w_step;
    logic           w_clear;

    mobius_round #(.N(N)) u_round (
        .d (r_data),
        .r (w_round_out)
    );

    // State register; reset abandons any vector in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake decode; in_ready follows out_ready in DONE so
    // a result drain and a new load can share one cycle.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load       = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                w_step = 1'b1;
                if (r_round_idx == c_last_round) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        w_load       = 1'b1;
                        w_state_next = RUN;
                    end else begin
                        w_clear      = 1'b1;
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Data register and round counter: load restarts the count, each RUN
    // cycle applies one round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data      <= '0;
            r_round_idx <= '0;
        end else begin
            if (w_load) begin
                r_data      <= in_data;
                r_round_idx <= '0;
            end else if (w_step) begin
                r_data      <= w_round_out;
                r_round_idx <= r_round_idx + 1'b1;
            end else if (w_clear) begin
                r_round_idx <= '0;
            end
        end
    end

    assign out_data  = r_data;
    assign round_idx = r_round_idx;

endmodule
`default_nettype wire
